// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_pkg
//  Purpose  : Shared types and constants for the SPI slave front-end.
//  Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

   localparam int DATA_W_DEF     = 8;
   localparam int CMD_W_DEF      = DATA_W_DEF + 2;
   localparam int RD_LATENCY_DEF = 2;

   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RECV    = 3'd1,
      WAIT_TX = 3'd2,
      SEND    = 3'd3,
      DONE    = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_if.sv
`default_nettype none
// ============================================================================
//  Module   : spi_if
//  Purpose  : SPI pins plus memory-side command/response signals.
//  Revision : 1.0 - initial release
// ============================================================================
interface spi_if
   import spi_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CMD_W  = CMD_W_DEF
);
   logic              ss_n;
   logic              mosi;
   logic              miso;
   logic [CMD_W-1:0]  rx_data;
   logic              rx_valid;
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;

   modport slave (
      input  ss_n, mosi, tx_data, tx_valid,
      output miso, rx_data, rx_valid
   );

   modport master (
      output ss_n, mosi, tx_data, tx_valid,
      input  miso, rx_data, rx_valid
   );
endinterface
`default_nettype wire

// File: rtl/spi_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : spi_tx_serializer
//  Purpose  : Loads a read byte and shifts it out MSB first on miso.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_tx_serializer
   import spi_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              shift,
   input  logic              clear,
   input  logic [DATA_W-1:0] data,
   output logic              miso,
   output logic              last
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] c_first_cnt = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

   logic [DATA_W-1:0] sh_q, sh_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              miso_q, miso_d;

   // cnt_q counts the bits still to come after the one currently on miso
   always_comb begin
      sh_d   = sh_q;
      cnt_d  = cnt_q;
      miso_d = miso_q;
      if (clear) begin
         sh_d   = '0;
         cnt_d  = '0;
         miso_d = 1'b0;
      end else if (load) begin
         sh_d   = data << 1;
         cnt_d  = c_first_cnt;
         miso_d = data[DATA_W-1];
      end else if (shift && (cnt_q != '0)) begin
         sh_d   = sh_q << 1;
         cnt_d  = cnt_q - c_one;
         miso_d = sh_q[DATA_W-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_q   <= '0;
         cnt_q  <= '0;
         miso_q <= 1'b0;
      end else begin
         sh_q   <= sh_d;
         cnt_q  <= cnt_d;
         miso_q <= miso_d;
      end
   end

   assign miso = miso_q;
   assign last = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/spi_slave_if.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slave_if
//  Purpose  : SPI slave front-end: 10-bit command receive, 8-bit read reply.
//             Optional read-order check enabled by SPI_RD_ORDER_CHECK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_slave_if
   import spi_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int CMD_W      = CMD_W_DEF,
   parameter int RD_LATENCY = RD_LATENCY_DEF
) (
   input  logic clk,
   input  logic rst_n,
   spi_if.slave bus
);

   localparam int CNT_MAX = (CMD_W > RD_LATENCY) ? CMD_W : RD_LATENCY;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(CMD_W - 1);
   localparam logic [CNT_W-1:0] c_rd_lat   = CNT_W'(RD_LATENCY);
   localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CMD_W-2:0] shift_q, shift_d;
   logic [CMD_W-1:0] rx_data_q, rx_data_d;
   logic             rx_valid_q, rx_valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tx_load, tx_shift, tx_clear, tx_last, tx_miso;
   logic [CMD_W-1:0] word;
   logic [1:0]       word_op;
`ifdef SPI_RD_ORDER_CHECK_EN
   logic             rd_addr_seen_q, rd_addr_seen_d;
`endif

   assign word    = {shift_q, bus.mosi};
   assign word_op = word[CMD_W-1 -: 2];

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      cnt_d      = cnt_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      tx_load    = 1'b0;
      tx_shift   = 1'b0;
      tx_clear   = 1'b0;
`ifdef SPI_RD_ORDER_CHECK_EN
      rd_addr_seen_d = rd_addr_seen_q;
`endif
      case (state_q)
         IDLE: begin
            if (!bus.ss_n) begin
               state_d = RECV;
               cnt_d   = '0;
               shift_d = '0;
            end
         end
         RECV: begin
            if (bus.ss_n) begin
               state_d = IDLE;
               cnt_d   = '0;
               shift_d = '0;
            end else if (cnt_q == c_last_bit) begin
               shift_d    = word[CMD_W-2:0];
               rx_data_d  = word;
               rx_valid_d = 1'b1;
               // cnt restarts at one: the pulse cycle itself counts as elapsed
               cnt_d      = c_one;
               state_d    = (word_op == OP_RD_DATA) ? WAIT_TX : DONE;
`ifdef SPI_RD_ORDER_CHECK_EN
               if (word_op == OP_RD_ADDR) begin
                  rd_addr_seen_d = 1'b1;
               end
               if (word_op == OP_RD_DATA) begin
                  rd_addr_seen_d = 1'b0;
                  if (!rd_addr_seen_q) begin
                     rx_valid_d = 1'b0;
                     state_d    = DONE;
                  end
               end
`endif
            end else begin
               shift_d = word[CMD_W-2:0];
               cnt_d   = cnt_q + c_one;
            end
         end
         WAIT_TX: begin
            if (bus.ss_n) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if ((cnt_q >= c_rd_lat) && bus.tx_valid) begin
               tx_load = 1'b1;
               cnt_d   = '0;
               state_d = SEND;
            end else if (cnt_q < c_rd_lat) begin
               cnt_d = cnt_q + c_one;
            end
         end
         SEND: begin
            if (bus.ss_n) begin
               tx_clear = 1'b1;
               state_d  = IDLE;
            end else if (tx_last) begin
               tx_clear = 1'b1;
               state_d  = DONE;
            end else begin
               tx_shift = 1'b1;
            end
         end
         DONE: begin
            if (bus.ss_n) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d  = IDLE;
            cnt_d    = '0;
            tx_clear = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         cnt_q      <= cnt_d;
      end
   end

`ifdef SPI_RD_ORDER_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_addr_seen_q <= 1'b0;
      end else begin
         rd_addr_seen_q <= rd_addr_seen_d;
      end
   end
`endif

   spi_tx_serializer #(
      .DATA_W (DATA_W)
   ) u_tx (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (tx_load),
      .shift (tx_shift),
      .clear (tx_clear),
      .data  (bus.tx_data),
      .miso  (tx_miso),
      .last  (tx_last)
   );

   assign bus.miso     = tx_miso;
   assign bus.rx_data  = rx_data_q;
   assign bus.rx_valid = rx_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_if.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_slave_if
//  Purpose  : Self-checking bench for spi_slave_if (frame-level model).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_if;
   import spi_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   spi_if #(.DATA_W(8), .CMD_W(10)) bus ();

   spi_slave_if #(
      .DATA_W     (8),
      .CMD_W      (10),
      .RD_LATENCY (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int         n_tests = 0;
   int         n_fail  = 0;
   bit         chk_en  = 1'b0;
   logic       exp_miso;
   logic       exp_rv;
   logic [9:0] exp_rd;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Per-cycle comparison against the frame-level expectations
   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         check("miso",     32'(bus.miso),     32'(exp_miso));
         check("rx_valid", 32'(bus.rx_valid), 32'(exp_rv));
         check("rx_data",  32'(bus.rx_data),  32'(exp_rd));
      end
   end

   task automatic step();
      @(negedge clk);
      exp_rv = 1'b0;
   endtask

   // Select low, then nbits of w MSB first; pulse tells whether a strobe is due
   task automatic send_frame(input logic [9:0] w, input int nbits, input bit pulse,
                             output int pulse_at);
      logic [9:0] ws;
      pulse_at = 0;
      step();
      bus.ss_n = 1'b0;
      bus.mosi = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         step();
         ws       = w << i;
         bus.mosi = ws[9];
         if (i == 9) begin
            exp_rd = w;
            exp_rv = pulse;
         end
         @(posedge clk);
         #1;
         if (bus.rx_valid) pulse_at = i + 2;
      end
   endtask

   task automatic end_frame(input int extra);
      for (int i = 0; i < extra; i++) begin
         step();
         bus.mosi = ~bus.mosi;
      end
      step();
      bus.ss_n = 1'b1;
      step();
   endtask

   // Read: tx_valid high from cycle d after the pulse (d=0: high all along)
   task automatic read_frame(input logic [7:0] data, input int d, input int rst_at,
                             output logic [11:0] got);
      int         pa;
      int         kc;
      logic [7:0] ds;
      got = '0;
      kc  = (d > 2) ? d : 2;
      bus.tx_data  = data;
      bus.tx_valid = (d == 0);
      send_frame({2'b11, 8'h00}, 10, 1'b1, pa);
      check("rd_pulse_edge", 32'(pa), 32'd11);
      for (int k = 1; k <= kc + 10; k++) begin
         step();
         bus.tx_valid = (k >= d);
         ds           = data << (k - kc);
         exp_miso     = (k >= kc && k < kc + 8) ? ds[7] : 1'b0;
         @(posedge clk);
         #1;
         if (k <= 12) got = {got[10:0], bus.miso};
         if (k == rst_at) begin
            #2;
            rst_n    = 1'b0;
            exp_miso = 1'b0;
            exp_rv   = 1'b0;
            exp_rd   = '0;
            #1;
            check("rst_async_miso",  32'(bus.miso),      32'd0);
            check("rst_async_rv",    32'(bus.rx_valid),  32'd0);
            check("rst_async_state", 32'(dut.state_q),   32'(IDLE));
            break;
         end
      end
      bus.tx_valid = 1'b0;
   endtask

   initial begin
      int          pa;
      logic [11:0] got;
      rst_n        = 1'b0;
      bus.ss_n     = 1'b1;
      bus.mosi     = 1'b0;
      bus.tx_data  = '0;
      bus.tx_valid = 1'b0;
      exp_miso     = 1'b0;
      exp_rv       = 1'b0;
      exp_rd       = '0;

      #7;
      check("reset_miso",  32'(bus.miso),     32'd0);
      check("reset_rv",    32'(bus.rx_valid), 32'd0);
      check("reset_rd",    32'(bus.rx_data),  32'd0);
      check("reset_state", 32'(dut.state_q),  32'(IDLE));
      chk_en = 1'b1;
      step();
      rst_n = 1'b1;
      step();

`ifdef SPI_RD_ORDER_CHECK_EN
      send_frame(10'h301, 10, 1'b0, pa);
      check("orphan_rd_no_pulse", 32'(pa), 32'd0);
      end_frame(3);
`endif

      // Write address, with stray tx_valid and overrun bits
      bus.tx_valid = 1'b1;
      send_frame(10'h005, 10, 1'b1, pa);
      check("wr_pulse_edge", 32'(pa),          32'd11);
      check("wr_rx_data",    32'(bus.rx_data), 32'h005);
      end_frame(4);
      bus.tx_valid = 1'b0;

      send_frame(10'h207, 10, 1'b1, pa);
      end_frame(0);
      read_frame(8'hA5, 0, 0, got);
      check("rd_a5_stream", 32'(got), 32'h528);
      end_frame(0);

      send_frame(10'h207, 10, 1'b1, pa);
      end_frame(0);
      read_frame(8'h3C, 5, 0, got);
      check("rd_3c_stream", 32'(got), 32'h03C);
      end_frame(0);

      // Abort after six bits, then a clean frame
      send_frame(10'h1FF, 6, 1'b0, pa);
      check("abort_no_pulse", 32'(pa), 32'd0);
      step();
      bus.ss_n = 1'b1;
      step();
      check("abort_rd_kept", 32'(bus.rx_data), 32'h300);
      send_frame(10'h080, 10, 1'b1, pa);
      check("post_abort_rd", 32'(bus.rx_data), 32'h080);
      end_frame(0);

      // Reset while bit 3 of 0xFF is on miso
      send_frame(10'h207, 10, 1'b1, pa);
      end_frame(0);
      read_frame(8'hFF, 0, 6, got);
      step();
      bus.ss_n = 1'b1;
      step();
      rst_n = 1'b1;
      step();
      step();
      check("post_rst_state", 32'(dut.state_q), 32'(IDLE));

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
